// File: rtl/llc_req_scheduler_pkg.sv
// Shared types and constants for the LLC request scheduler.
//  - trace command codes (L1-side 0,1,2,8,9; snoop 3..6; 7 and >9 illegal)
//  - bus operation and scheduler state encodings
//  - req_t: {cmd, addr} pair carried through the FIFO and holding register
package llc_req_scheduler_pkg;

    localparam int CMDSIZE          = 4;
    localparam int ADDR_BITS        = 32;
    localparam int BYTE_OFFSET_BITS = 6;

    localparam logic [CMDSIZE-1:0] CMD_READ      = 4'd0;
    localparam logic [CMDSIZE-1:0] CMD_WRITE     = 4'd1;
    localparam logic [CMDSIZE-1:0] CMD_IFETCH    = 4'd2;
    localparam logic [CMDSIZE-1:0] CMD_SNP_INV   = 4'd3;
    localparam logic [CMDSIZE-1:0] CMD_SNP_READ  = 4'd4;
    localparam logic [CMDSIZE-1:0] CMD_SNP_WRITE = 4'd5;
    localparam logic [CMDSIZE-1:0] CMD_SNP_RWIM  = 4'd6;
    localparam logic [CMDSIZE-1:0] CMD_CLEAR     = 4'd8;
    localparam logic [CMDSIZE-1:0] CMD_PRINT     = 4'd9;

    typedef enum logic [1:0] {
        BUS_READ, BUS_WRITE, BUS_INVALIDATE, BUS_RWIM
    } bus_op_t;

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_WB, S_FILL, S_INV, S_DONE
    } sched_state_t;

    typedef struct packed {
        logic [CMDSIZE-1:0]   cmd;
        logic [ADDR_BITS-1:0] addr;
    } req_t;

    function automatic logic cmd_illegal(input logic [CMDSIZE-1:0] c);
        return (c == 4'd7) || (c > 4'd9);
    endfunction

    // Data read / write / instruction fetch: the commands that can miss and fill
    function automatic logic cmd_is_rw(input logic [CMDSIZE-1:0] c);
        return (c == CMD_READ) || (c == CMD_WRITE) || (c == CMD_IFETCH);
    endfunction

endpackage

// File: rtl/llc_req_scheduler_fifo.sv
// llc_req_fifo: synchronous FIFO, DEPTH entries of W bits.
//  i_clk, i_rst   clock, synchronous active-high reset
//  i_push/i_data  write (ignored when full)
//  i_pop          read (ignored when empty)
//  o_head         entry at the read pointer
//  o_full/o_empty status
module llc_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);

    // Pointers carry an extra wrap bit to tell full from empty
    logic [AW:0]  r_wr_ptr, r_rd_ptr;
    logic [W-1:0] r_mem [DEPTH];

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push && !o_full) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop && !o_empty) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push && !o_full) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/llc_req_scheduler.sv
// llc_req_scheduler: arbitrates L1 requests (FIFO) against snoops (one-entry
// holding register), issues one LLC lookup at a time and sequences the
// resulting bus operations (victim writeback, fill, invalidate).
//  i_p_*   processor request in (valid/ready, cmd, addr)
//  i_s_*   snoop request in (valid/ready, cmd, addr)
//  o_l_*   LLC lookup out; i_l_* lookup result (done pulse, hit, need_wb, shared, wb_addr)
//  o_bus_* bus operation out; i_bus_ack accepts it
//  o_busy, o_done (retire pulse), o_bad_cmd (illegal command dropped pulse)
module llc_req_scheduler
    import llc_req_scheduler_pkg::*;
#(
    parameter int PQ_DEPTH     = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_p_valid,
    output logic                 o_p_ready,
    input  logic [CMDSIZE-1:0]   i_p_cmd,
    input  logic [ADDR_BITS-1:0] i_p_addr,
    input  logic                 i_s_valid,
    output logic                 o_s_ready,
    input  logic [CMDSIZE-1:0]   i_s_cmd,
    input  logic [ADDR_BITS-1:0] i_s_addr,
    output logic                 o_l_valid,
    input  logic                 i_l_ready,
    output logic [CMDSIZE-1:0]   o_l_cmd,
    output logic [ADDR_BITS-1:0] o_l_addr,
    input  logic                 i_l_done,
    input  logic                 i_l_hit,
    input  logic                 i_l_need_wb,
    input  logic                 i_l_shared,
    input  logic [ADDR_BITS-1:0] i_l_wb_addr,
    output logic                 o_bus_valid,
    output bus_op_t              o_bus_op,
    output logic [ADDR_BITS-1:0] o_bus_addr,
    input  logic                 i_bus_ack,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_bad_cmd
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    sched_state_t r_state, w_next;

    logic [$bits(req_t)-1:0] w_head_raw;
    req_t    w_head, w_grant_req, r_s_req, r_req;
    logic    w_fifo_full, w_fifo_empty;
    logic    r_s_held, r_req_snoop;
    logic [ADDR_BITS-1:0] r_wb_addr, w_line_addr;
    logic [SW-1:0] r_starve;
    logic    r_l_valid, r_bus_valid, r_bad_cmd;
    logic    w_head_barrier, w_pick_snoop, w_grant_s, w_grant_p, w_grant_bad;

    llc_req_fifo #(.DEPTH(PQ_DEPTH), .W($bits(req_t))) u_fifo (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_push (i_p_valid),
        .i_data ({i_p_cmd, i_p_addr}),
        .i_pop  (w_grant_p),
        .o_head (w_head_raw),
        .o_full (w_fifo_full),
        .o_empty(w_fifo_empty)
    );

    assign w_head    = req_t'(w_head_raw);
    assign o_p_ready = !w_fifo_full;
    assign o_s_ready = !r_s_held;

    // A barrier (8/9) at the head yields to a held snoop even past the
    // starvation limit; otherwise the two would block each other forever.
    assign w_head_barrier = (w_head.cmd == CMD_CLEAR) || (w_head.cmd == CMD_PRINT);
    assign w_pick_snoop   = r_s_held && ((r_starve < SW'(STARVE_LIMIT)) ||
                                         w_fifo_empty || w_head_barrier);
    assign w_grant_s      = (r_state == S_IDLE) && w_pick_snoop;
    assign w_grant_p      = (r_state == S_IDLE) && !w_pick_snoop && !w_fifo_empty;
    assign w_grant_req    = w_grant_s ? r_s_req : w_head;
    assign w_grant_bad    = cmd_illegal(w_grant_req.cmd);
    assign w_line_addr    = {r_req.addr[ADDR_BITS-1:BYTE_OFFSET_BITS],
                             {BYTE_OFFSET_BITS{1'b0}}};

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if ((w_grant_s || w_grant_p) && !w_grant_bad) w_next = S_ISSUE;
            S_ISSUE: if (r_l_valid && i_l_ready) w_next = S_WAIT;
            S_WAIT: if (i_l_done) begin
                if (!r_req_snoop && cmd_is_rw(r_req.cmd) && !i_l_hit)
                    w_next = i_l_need_wb ? S_WB : S_FILL;
                else if (!r_req_snoop && (r_req.cmd == CMD_WRITE) && i_l_hit && i_l_shared)
                    w_next = S_INV;
                else if (r_req_snoop && ((r_req.cmd == CMD_SNP_READ) ||
                         (r_req.cmd == CMD_SNP_RWIM)) && i_l_hit && i_l_need_wb)
                    w_next = S_WB;
                else
                    w_next = S_DONE;
            end
            S_WB:    if (r_bus_valid && i_bus_ack) w_next = r_req_snoop ? S_DONE : S_FILL;
            S_FILL,
            S_INV:   if (r_bus_valid && i_bus_ack) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        o_bus_op   = BUS_READ;
        o_bus_addr = '0;
        case (r_state)
            S_WB:   begin o_bus_op = BUS_WRITE; o_bus_addr = r_wb_addr; end
            S_FILL: begin
                o_bus_op   = (r_req.cmd == CMD_WRITE) ? BUS_RWIM : BUS_READ;
                o_bus_addr = w_line_addr;
            end
            S_INV:  begin o_bus_op = BUS_INVALIDATE; o_bus_addr = w_line_addr; end
            default: ;
        endcase
    end

    assign o_done      = (r_state == S_DONE);
    assign o_busy      = (r_state != S_IDLE) || !w_fifo_empty || r_s_held;
    assign o_l_valid   = r_l_valid;
    assign o_l_cmd     = r_req.cmd;
    assign o_l_addr    = r_req.addr;
    assign o_bus_valid = r_bus_valid;
    assign o_bad_cmd   = r_bad_cmd;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s_held    <= 1'b0;
            r_s_req     <= '0;
            r_req       <= '0;
            r_req_snoop <= 1'b0;
            r_wb_addr   <= '0;
            r_starve    <= '0;
            r_l_valid   <= 1'b0;
            r_bus_valid <= 1'b0;
            r_bad_cmd   <= 1'b0;
        end else begin
            r_bad_cmd <= (w_grant_s || w_grant_p) && w_grant_bad;

            if (w_grant_s)
                r_s_held <= 1'b0;
            else if (i_s_valid && !r_s_held) begin
                r_s_held <= 1'b1;
                r_s_req  <= '{cmd: i_s_cmd, addr: i_s_addr};
            end

            if ((w_grant_s || w_grant_p) && !w_grant_bad) begin
                r_req       <= w_grant_req;
                r_req_snoop <= w_grant_s;
            end

            if (w_grant_p)
                r_starve <= '0;
            else if (w_grant_s && !w_fifo_empty && (r_starve < SW'(STARVE_LIMIT)))
                r_starve <= r_starve + 1'b1;

            // l_valid rises one cycle into ISSUE and drops on the accept edge
            r_l_valid <= (r_state == S_ISSUE) && !(r_l_valid && i_l_ready);

            if ((r_state == S_WAIT) && i_l_done) r_wb_addr <= i_l_wb_addr;

            // Clearing on ack forces a one-cycle gap between WB and FILL so
            // each bus op gets its own valid run.
            r_bus_valid <= (w_next inside {S_WB, S_FILL, S_INV}) &&
                           !(r_bus_valid && i_bus_ack);
        end
    end

endmodule

// File: tb/tb_llc_req_scheduler.sv
module tb_llc_req_scheduler;
    import llc_req_scheduler_pkg::*;

    logic clk = 1'b0;
    logic rst, p_valid, s_valid, l_ready, l_done, l_hit, l_need_wb, l_shared, bus_ack;
    logic [CMDSIZE-1:0]   p_cmd, s_cmd, l_cmd;
    logic [ADDR_BITS-1:0] p_addr, s_addr, l_addr, l_wb_addr, bus_addr;
    logic p_ready, s_ready, l_valid, bus_valid, busy, done, bad_cmd;
    bus_op_t bus_op;

    typedef struct packed { bus_op_t op; logic [31:0] addr; } bop_t;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int badp_cnt = 0;
    logic [CMDSIZE+ADDR_BITS-1:0] snq[$];
    bop_t exp_q[$];
    logic [3:0] pcmds [10] = '{4'd0, 4'd1, 4'd2, 4'd0, 4'd1, 4'd2, 4'd8, 4'd9, 4'd7, 4'd12};

    llc_req_scheduler #(.PQ_DEPTH(4), .STARVE_LIMIT(3)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_p_valid(p_valid), .o_p_ready(p_ready), .i_p_cmd(p_cmd), .i_p_addr(p_addr),
        .i_s_valid(s_valid), .o_s_ready(s_ready), .i_s_cmd(s_cmd), .i_s_addr(s_addr),
        .o_l_valid(l_valid), .i_l_ready(l_ready), .o_l_cmd(l_cmd), .o_l_addr(l_addr),
        .i_l_done(l_done), .i_l_hit(l_hit), .i_l_need_wb(l_need_wb), .i_l_shared(l_shared),
        .i_l_wb_addr(l_wb_addr),
        .o_bus_valid(bus_valid), .o_bus_op(bus_op), .o_bus_addr(bus_addr), .i_bus_ack(bus_ack),
        .o_busy(busy), .o_done(done), .o_bad_cmd(bad_cmd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done)    done_cnt <= done_cnt + 1;
        if (bad_cmd) badp_cnt <= badp_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected bus ops for one retired request, straight from the sequencing rules
    function automatic void model(input bit snp, input logic [3:0] c, input logic [31:0] a,
                                  input bit hit, input bit nwb, input bit shr,
                                  input logic [31:0] wba);
        logic [31:0] line;
        line = {a[31:6], 6'b0};
        if (!snp && c <= 4'd2 && !hit) begin
            if (nwb) exp_q.push_back(bop_t'({BUS_WRITE, wba}));
            exp_q.push_back(bop_t'({(c == 4'd1) ? BUS_RWIM : BUS_READ, line}));
        end else if (!snp && c == 4'd1 && hit && shr) begin
            exp_q.push_back(bop_t'({BUS_INVALIDATE, line}));
        end else if (snp && (c == 4'd4 || c == 4'd6) && hit && nwb) begin
            exp_q.push_back(bop_t'({BUS_WRITE, wba}));
        end
    endfunction

    task automatic push_p(input logic [3:0] c, input logic [31:0] a);
        int n;
        n = 0;
        @(negedge clk);
        p_valid = 1'b1; p_cmd = c; p_addr = a;
        while (!p_ready && n < 300) begin @(negedge clk); n++; end
        chk("p_accept", 64'(p_ready), 64'(1));
        @(posedge clk); #1;
        p_valid = 1'b0;
    endtask

    task automatic push_s(input logic [3:0] c, input logic [31:0] a);
        int n;
        n = 0;
        @(negedge clk);
        s_valid = 1'b1; s_cmd = c; s_addr = a;
        while (!s_ready && n < 300) begin @(negedge clk); n++; end
        chk("s_accept", 64'(s_ready), 64'(1));
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    // Act as the LLC: accept the lookup (after 'stall' cycles) and return a result
    task automatic llc_phase(input logic [3:0] ec, input logic [31:0] ea, input bit hit,
                             input bit nwb, input bit shr, input logic [31:0] wba,
                             input int stall);
        int n;
        n = 0;
        @(negedge clk);
        while (!l_valid && n < 200) begin @(negedge clk); n++; end
        chk("l_valid_seen", 64'(l_valid), 64'(1));
        if (snq.size() != 0 && s_ready) begin
            {s_cmd, s_addr} = snq.pop_front();
            s_valid = 1'b1;
        end
        chk("l_cmd", 64'(l_cmd), 64'(ec));
        chk("l_addr", 64'(l_addr), 64'(ea));
        for (int i = 0; i < stall; i++) begin
            l_done = 1'b1;  // spurious done while still in ISSUE
            @(negedge clk);
            s_valid = 1'b0;
            chk("l_hold", 64'({l_valid, l_cmd, l_addr}), 64'({1'b1, ec, ea}));
        end
        l_done = 1'b0;
        l_ready = 1'b1;
        @(negedge clk);
        l_ready = 1'b0; s_valid = 1'b0;
        chk("l_valid_drop", 64'(l_valid), 64'(0));
        l_done = 1'b1; l_hit = hit; l_need_wb = nwb; l_shared = shr; l_wb_addr = wba;
        @(negedge clk);
        l_done = 1'b0;
    endtask

    task automatic bus_phase(input bus_op_t op, input logic [31:0] a);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus_valid && n < 200) begin @(negedge clk); n++; end
        chk("bus_valid_seen", 64'(bus_valid), 64'(1));
        chk("bus_op", 64'(bus_op), 64'(op));
        chk("bus_addr", 64'(bus_addr), 64'(a));
        @(negedge clk);
        chk("bus_hold", 64'({bus_valid, bus_op, bus_addr}), 64'({1'b1, op, a}));
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("bus_drop", 64'(bus_valid), 64'(0));
    endtask

    task automatic finish_phase(input int d0);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        chk("done_pulses", 64'(done_cnt - d0), 64'(1));
        chk("done_low", 64'(done), 64'(0));
        chk("bus_idle", 64'(bus_valid), 64'(0));
    endtask

    task automatic run_op(input bit snp, input logic [3:0] c, input logic [31:0] a,
                          input bit hit, input bit nwb, input bit shr,
                          input logic [31:0] wba, input int stall);
        int d0;
        bop_t b;
        d0 = done_cnt;
        exp_q.delete();
        model(snp, c, a, hit, nwb, shr, wba);
        llc_phase(c, a, hit, nwb, shr, wba, stall);
        while (exp_q.size() != 0) begin
            b = exp_q.pop_front();
            bus_phase(b.op, b.addr);
        end
        finish_phase(d0);
    endtask

    task automatic check_illegal(input logic [3:0] c, input logic [31:0] a);
        int b0;
        logic seen;
        b0 = badp_cnt;
        seen = 1'b0;
        push_p(c, a);
        repeat (5) begin @(negedge clk); seen = seen | l_valid; end
        chk("bad_pulse", 64'(badp_cnt - b0), 64'(1));
        chk("bad_no_lvalid", 64'(seen), 64'(0));
    endtask

    initial begin
        int n, d0, b0;
        bit snp, hit, nwb, shr;
        logic [3:0] c;
        logic [31:0] a, wba;

        rst = 1'b1; p_valid = 0; s_valid = 0; l_ready = 0; l_done = 0; l_hit = 0;
        l_need_wb = 0; l_shared = 0; bus_ack = 0;
        p_cmd = '0; s_cmd = '0; p_addr = '0; s_addr = '0; l_wb_addr = '0;
        repeat (3) @(negedge clk);
        chk("rst_outs", 64'({l_valid, bus_valid, done, bad_cmd, busy}), 64'(0));
        chk("rst_l", 64'({l_cmd, l_addr}), 64'(0));
        chk("rst_bus", 64'({bus_op, bus_addr}), 64'(0));
        chk("rst_ready", 64'({p_ready, s_ready}), 64'(2'b11));
        rst = 1'b0;

        // 1: miss with dirty victim -> WRITE victim then READ fill
        d0 = done_cnt;
        push_p(4'd0, 32'h1000);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!l_valid && n < 10);
        chk("accept_to_lvalid", 64'(n), 64'(2));
        llc_phase(4'd0, 32'h1000, 0, 1, 0, 32'h2000, 0);
        bus_phase(BUS_WRITE, 32'h2000);
        bus_phase(BUS_READ, 32'h1000);
        finish_phase(d0);

        // 2: write hit on S -> single INVALIDATE
        d0 = done_cnt;
        push_p(4'd1, 32'h40);
        llc_phase(4'd1, 32'h40, 1, 0, 1, 32'h0, 1);
        bus_phase(BUS_INVALIDATE, 32'h40);
        finish_phase(d0);

        // 3: starvation limit -> S,S,S,P,S,S,P
        b0 = badp_cnt;
        push_p(4'd9, 32'h0);             // held in ISSUE while queues fill
        push_p(4'd0, 32'h100);
        push_p(4'd0, 32'h200);
        push_s(4'd3, 32'hA00);
        snq.push_back({4'd5, 32'hB00});
        snq.push_back({4'd3, 32'hC00});
        snq.push_back({4'd4, 32'hD00});
        snq.push_back({4'd6, 32'hE00});
        run_op(0, 4'd9, 32'h0, 0, 0, 0, 32'h0, 0);
        run_op(1, 4'd3, 32'hA00, 0, 0, 0, 32'h0, 0);
        run_op(1, 4'd5, 32'hB00, 0, 0, 0, 32'h0, 0);
        run_op(1, 4'd3, 32'hC00, 0, 0, 0, 32'h0, 0);
        run_op(0, 4'd0, 32'h100, 1, 0, 0, 32'h0, 0);
        run_op(1, 4'd4, 32'hD00, 0, 0, 0, 32'h0, 0);
        run_op(1, 4'd6, 32'hE00, 0, 0, 0, 32'h0, 0);
        run_op(0, 4'd0, 32'h200, 1, 0, 0, 32'h0, 0);
        chk("order_no_bad", 64'(badp_cnt - b0), 64'(0));

        // 4: FIFO full while the scheduler is stalled
        push_p(4'd9, 32'h9);
        push_p(4'd0, 32'h1100);
        push_p(4'd0, 32'h1200);
        push_p(4'd0, 32'h1300);
        chk("p_ready_3", 64'(p_ready), 64'(1));
        push_p(4'd0, 32'h1400);
        @(negedge clk);
        chk("p_ready_full", 64'(p_ready), 64'(0));
        fork
            push_p(4'd0, 32'h1500);
            begin
                repeat (3) @(negedge clk);
                chk("p_ready_full_hold", 64'(p_ready), 64'(0));
                run_op(0, 4'd9, 32'h9, 0, 0, 0, 32'h0, 0);
            end
        join
        for (int i = 1; i <= 5; i++)
            run_op(0, 4'd0, 32'h1000 + 32'(i) * 32'h100, 1, 0, 0, 32'h0, 0);

        // 5: barrier behind a held snoop, then an illegal command
        push_p(4'd9, 32'h9);
        push_p(4'd8, 32'h300);
        push_s(4'd3, 32'h400);
        run_op(0, 4'd9, 32'h9, 0, 0, 0, 32'h0, 0);
        run_op(1, 4'd3, 32'h400, 0, 0, 0, 32'h0, 0);
        run_op(0, 4'd8, 32'h300, 0, 0, 0, 32'h0, 0);
        check_illegal(4'd7, 32'h500);

        // 6: reset while a writeback is on the bus
        d0 = done_cnt;
        push_p(4'd0, 32'h3000);
        llc_phase(4'd0, 32'h3000, 0, 1, 0, 32'h5000, 0);
        n = 0;
        while (!bus_valid && n < 200) begin @(negedge clk); n++; end
        chk("rst_wb_op", 64'({bus_valid, bus_op}), 64'({1'b1, BUS_WRITE}));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid", 64'({bus_valid, busy, l_valid, done}), 64'(0));
        repeat (3) @(negedge clk);
        chk("rst_no_done", 64'(done_cnt - d0), 64'(0));
        d0 = done_cnt;
        push_p(4'd0, 32'h3000);
        llc_phase(4'd0, 32'h3000, 0, 0, 0, 32'h0, 0);
        bus_phase(BUS_READ, 32'h3000);
        finish_phase(d0);

        // Randomised single requests against the rule model
        for (int k = 0; k < 40; k++) begin
            snp = ($urandom_range(0, 3) == 0);
            c   = snp ? 4'(3 + $urandom_range(0, 3)) : pcmds[$urandom_range(0, 9)];
            a   = $urandom;
            hit = 1'($urandom_range(0, 1));
            nwb = 1'($urandom_range(0, 1));
            shr = 1'($urandom_range(0, 1));
            wba = {$urandom_range(0, 32'h03FF_FFFF) , 6'b0} ;
            if (!snp && (c == 4'd7 || c > 4'd9)) begin
                check_illegal(c, a);
            end else begin
                if (snp) push_s(c, a);
                else     push_p(c, a);
                run_op(snp, c, a, hit, nwb, shr, wba, $urandom_range(0, 2));
                chk("idle_busy", 64'(busy), 64'(0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
